lfsr8: RTL and testbench

//   8-bit Fibonacci linear-feedback shift register: a free-running pseudo-random byte source.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_feedback.sv | 14 +
 rtl/lfsr8.sv | 58 +++++
 tb/tb_lfsr8.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and reference next-state function for the 8-bit Fibonacci LFSR
// (polynomial x^8+x^4+x^3+x^2+1).
package lfsr_pkg;

  localparam int                    LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 8'h8A;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 8'h1D;

  // A zero state would lock the register, so it is steered back to the seed.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    if (state == {LFSR_WIDTH{1'b0}}) begin
      return LFSR_SEED;
    end else begin
      return {fb, state[LFSR_WIDTH-1:1]};
    end
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Feedback bit of a Fibonacci LFSR: XOR-reduction of the state bits selected by TAPS.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] i_state,
  output logic             o_fb
);

  assign o_fb = ^(i_state & TAPS);

endmodule

// File: rtl/lfsr8.sv
// Free-running 8-bit pseudo-random byte source with synchronous reset to SEED.
// Optional parallel load is compiled in when LFSR_LOAD_EN is defined.
module lfsr8
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LFSR_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;
  logic             w_fb;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .i_state (r_data),
    .o_fb    (w_fb)
  );

  // Next state: reset beats load beats step; a zero state or zero load restarts at SEED.
  always_comb begin
    w_next = r_data;
    if (reset) begin
      w_next = SEED;
`ifdef LFSR_LOAD_EN
    end else if (load) begin
      if (load_value == {WIDTH{1'b0}}) begin
        w_next = SEED;
      end else begin
        w_next = load_value;
      end
`endif
    end else if (r_data == {WIDTH{1'b0}}) begin
      w_next = SEED;
    end else begin
      w_next = {w_fb, r_data[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    r_data <= w_next;
  end

  assign data = r_data;

endmodule

// File: tb/tb_lfsr8.sv
// Scoreboard bench for lfsr8: the driver queues expected bytes, a monitor checks data
// one clock later.
module tb_lfsr8;
  import lfsr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] data;

  always #5 clk = ~clk;

  lfsr8 dut (
    .clk        (clk),
    .reset      (reset),
`ifdef LFSR_LOAD_EN
    .load       (load),
    .load_value (load_value),
`endif
    .data       (data)
  );

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [7:0] model;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         seen[256];
  logic [7:0] m_exp;
  string      m_tag;

  // One posedge after each queued cycle, compare data against the expected byte.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      n_checks++;
      if (data !== m_exp) begin
        n_fail++;
        $display("FAIL %s: data=%h expected=%h", m_tag, data, m_exp);
      end
      if (m_tag == "rst") begin
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[m_exp] = 1'b1;
      end
      if (m_tag == "period") begin
        n_checks++;
        if (data === 8'h00 || seen[data]) begin
          n_fail++;
          $display("FAIL period_unique: data=%h repeated or zero before edge 255", data);
        end
        seen[data] = 1'b1;
      end
    end
  end

  // Apply one cycle of inputs and queue its expected result (hand value or model).
  task automatic drive(input logic rst, input logic ld, input logic [7:0] lv,
                       input string tag, input bit use_hand, input logic [7:0] hand);
    @(negedge clk);
    reset      = rst;
    load       = ld;
    load_value = lv;
    if (rst) begin
      model = LFSR_SEED;
    end else if (ld) begin
      model = (lv == 8'h00) ? LFSR_SEED : lv;
    end else begin
      model = lfsr_pkg::lfsr_next(model);
    end
    exp_q.push_back(use_hand ? hand : model);
    tag_q.push_back(tag);
  endtask

  task automatic step(input string tag);
    drive(1'b0, 1'b0, 8'h00, tag, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] steps_hand[5];
    int         run_len;
    int         drain;

    steps_hand[0] = 8'hC5;
    steps_hand[1] = 8'h62;
    steps_hand[2] = 8'h31;
    steps_hand[3] = 8'h18;
    steps_hand[4] = 8'h0C;

    drive(1'b1, 1'b0, 8'h00, "rst", 1'b1, 8'h8A);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00, "rst_hold", 1'b1, 8'h8A);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, "step", 1'b1, steps_hand[i]);

    drive(1'b1, 1'b0, 8'h00, "rst", 1'b1, 8'h8A);
    for (int i = 1; i < 255; i++) step("period");
    drive(1'b0, 1'b0, 8'h00, "period_end", 1'b1, 8'h8A);

    for (int i = 0; i < 37; i++) step("pre_midrst");
    drive(1'b1, 1'b0, 8'h00, "midrst", 1'b1, 8'h8A);
    drive(1'b0, 1'b0, 8'h00, "after_midrst", 1'b1, 8'hC5);

`ifdef LFSR_LOAD_EN
    drive(1'b0, 1'b1, 8'h5A, "load", 1'b1, 8'h5A);
    drive(1'b0, 1'b0, 8'h00, "load_step", 1'b1, 8'h2D);
    drive(1'b0, 1'b1, 8'h00, "load_zero", 1'b1, 8'h8A);
    step("load_zero_step");
    drive(1'b1, 1'b1, 8'h33, "rst_over_load", 1'b1, 8'h8A);
`endif

    for (int r = 0; r < 1000; r++) begin
      run_len = $urandom_range(1, 12);
      for (int i = 0; i < run_len; i++) step("model");
      if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, 8'h00, "model_rst", 1'b0, 8'h00);
    end

    @(negedge clk);
    reset = 1'b0;
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
